// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared types, limits and round-robin scan helper for the Wishbone arbiter
package wb_arb_pkg;
  localparam int ARB_MAX_MASTERS = 8;
  localparam int ARB_IDX_W = $clog2(ARB_MAX_MASTERS);
  typedef enum logic {IDLE, OWNED} arb_state_e;
  function automatic logic [ARB_IDX_W-1:0] rr_next(input logic [ARB_MAX_MASTERS-1:0] req,
                                                   input logic [ARB_IDX_W-1:0] last);
    logic [ARB_IDX_W-1:0] c;
    logic found;
    rr_next = last;
    found = 1'b0;
    for (int i = 1; i <= ARB_MAX_MASTERS; i++) begin
      c = last + ARB_IDX_W'(i);
      if (!found && req[c]) begin
        rr_next = c;
        found = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/wb_arbiter_rr_if.sv
// wb_arb_if: request/response and grant signals between the masters and the arbiter
interface wb_arb_if #(parameter int NUMM = 3) ();
  localparam int IW = $clog2(NUMM);
  logic [NUMM-1:0] cyc_i;
  logic [NUMM-1:0] stb_i;
  logic            bus_ack_i;
  logic            bus_err_i;
  logic [NUMM-1:0] gnt_o;
  logic [IW-1:0]   gnt_idx_o;
  logic            busy_o;
  logic            to_err_o;
  modport slave (input cyc_i, stb_i, bus_ack_i, bus_err_i,
                 output gnt_o, gnt_idx_o, busy_o, to_err_o);
  modport master (output cyc_i, stb_i, bus_ack_i, bus_err_i,
                  input gnt_o, gnt_idx_o, busy_o, to_err_o);
endinterface

// File: rtl/wb_arbiter_rr_pick.sv
// wb_arb_rr_pick: combinational round-robin picker, previous owner at lowest priority
module wb_arb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUMM = 3,
  localparam int IW = $clog2(NUMM)
) (
  input  logic [NUMM-1:0] req,
  input  logic [IW-1:0]   last,
  output logic            valid,
  output logic [NUMM-1:0] sel,
  output logic [IW-1:0]   idx
);
  // Zero-padding req to the maximum width leaves the modulo-NUMM scan order unchanged
  assign valid = |req;
  assign idx = IW'(rr_next(ARB_MAX_MASTERS'(req), ARB_IDX_W'(last)));
  assign sel = valid ? NUMM'(1) << idx : '0;
endmodule

// File: rtl/wb_arbiter_rr.sv
// wb_arbiter_rr: round-robin Wishbone bus-ownership arbiter; WB_ARB_TIMEOUT_EN enables the stall watchdog
module wb_arbiter_rr
  import wb_arb_pkg::*;
#(
  parameter int NUMM = 3,
  parameter int TIMEOUT = 255
) (
  input logic     clk,
  input logic     rst_n,
  wb_arb_if.slave bus
);
  localparam int IW = $clog2(NUMM);
  arb_state_e state_q, state_d;
  logic [NUMM-1:0] gnt_q, gnt_d, pick_sel;
  logic [IW-1:0] idx_q, idx_d, last_q, last_d, pick_idx;
  logic pick_valid, arb;
  wb_arb_rr_pick #(.NUMM(NUMM)) u_pick (
    .req(bus.cyc_i), .last(last_q), .valid(pick_valid), .sel(pick_sel), .idx(pick_idx)
  );
  assign arb = state_q == IDLE || !bus.cyc_i[idx_q];
  // Re-arbitrate only when idle or the owner has released cyc; otherwise hold everything
  always_comb begin
    state_d = arb ? (pick_valid ? OWNED : IDLE) : state_q;
    gnt_d = arb ? pick_sel : gnt_q;
    idx_d = arb && pick_valid ? pick_idx : idx_q;
    last_d = arb && pick_valid ? pick_idx : last_q;
  end
  // Grant registers; last starts at NUMM-1 so master 0 wins the first contention
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q <= '0;
      idx_q <= '0;
      last_q <= IW'(NUMM - 1);
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      last_q <= last_d;
    end
  end
  assign bus.gnt_o = gnt_q;
  assign bus.gnt_idx_o = idx_q;
  assign bus.busy_o = |gnt_q;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic to_q, to_d, stall, hit;
  // Count owner cycles left unanswered; a response, idle stb or grant change restarts the count
  always_comb begin
    stall = state_q == OWNED && gnt_d == gnt_q && bus.stb_i[idx_q] && !bus.bus_ack_i && !bus.bus_err_i;
    hit = stall && cnt_q == CW'(TIMEOUT - 1);
    cnt_d = stall && !hit ? cnt_q + 1'b1 : '0;
    to_d = hit;
  end
  // Watchdog counter and one-cycle timeout pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      to_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      to_q <= to_d;
    end
  end
  assign bus.to_err_o = to_q;
`else
  logic unused_wd;
  assign unused_wd = &{1'b0, bus.stb_i, bus.bus_ack_i, bus.bus_err_i, 32'(TIMEOUT)};
  assign bus.to_err_o = 1'b0;
`endif
endmodule
